coin_start_sequencer: RTL

//  Turns the player "start" requests (keyboard/joystick OR) into timed arcade

---
 rtl/coin_start_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/coin_start_sequencer.sv
// Sequences player start requests into timed coin1 / start pulses for the game core, timed in frames.
// Optional build macro SERVICE_COIN_EN adds coin_req: a coin credit with no start pulse.
module coin_start_sequencer #(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4,
    parameter int FRAME_W      = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic frame_ce,
    input  logic start1_req,
    input  logic start2_req,
`ifdef SERVICE_COIN_EN
    input  logic coin_req,
`endif
    output logic coin1,
    output logic start1,
    output logic start2,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, COIN, GAP, START, HOLD} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_1P, SEL_2P} sel_t;

    localparam logic [FRAME_W-1:0] COIN_LAST  = FRAME_W'(COIN_FRAMES - 1);
    localparam logic [FRAME_W-1:0] GAP_LAST   = FRAME_W'(GAP_FRAMES - 1);
    localparam logic [FRAME_W-1:0] START_LAST = FRAME_W'(START_FRAMES - 1);

    state_t             state, state_nxt;
    sel_t               sel, sel_nxt;
    logic [1:0]         coins_left, coins_nxt;
    logic [FRAME_W-1:0] cnt;
    logic               s1_q, s2_q;
    logic               s1_rise, s2_rise, coin_rise, any_req;

    assign s1_rise = start1_req & ~s1_q;
    assign s2_rise = start2_req & ~s2_q;

`ifdef SERVICE_COIN_EN
    logic c_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) c_q <= 1'b0;
        else          c_q <= coin_req;
    end
    assign coin_rise = coin_req & ~c_q;
    assign any_req   = start1_req | start2_req | coin_req;
`else
    assign coin_rise = 1'b0;
    assign any_req   = start1_req | start2_req;
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        coins_nxt = coins_left;
        case (state)
            IDLE: begin
                if (s1_rise) begin
                    state_nxt = COIN;
                    sel_nxt   = SEL_1P;
                    coins_nxt = 2'd1;
                end else if (s2_rise) begin
                    state_nxt = COIN;
                    sel_nxt   = SEL_2P;
                    coins_nxt = 2'd2;
                end else if (coin_rise) begin
                    state_nxt = COIN;
                    sel_nxt   = SEL_NONE;
                    coins_nxt = 2'd1;
                end
            end
            COIN:  if (frame_ce && cnt == COIN_LAST) state_nxt = GAP;
            GAP: begin
                if (frame_ce && cnt == GAP_LAST) begin
                    coins_nxt = coins_left - 2'd1;
                    if (coins_nxt != 2'd0)     state_nxt = COIN;
                    else if (sel == SEL_NONE) state_nxt = HOLD;
                    else                      state_nxt = START;
                end
            end
            START: if (frame_ce && cnt == START_LAST) state_nxt = HOLD;
            // Wait for every button to be released so a held button never retriggers.
            HOLD:  if (!any_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sel        <= SEL_NONE;
            coins_left <= 2'd0;
            cnt        <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            coin1      <= 1'b0;
            start1     <= 1'b0;
            start2     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            coins_left <= coins_nxt;
            s1_q       <= start1_req;
            s2_q       <= start2_req;
            if (state_nxt != state) cnt <= '0;
            else if (frame_ce)      cnt <= cnt + 1'b1;
            // Outputs decode the next state so they settle on the same edge as the state.
            coin1      <= (state_nxt == COIN);
            start1     <= (state_nxt == START) && (sel_nxt == SEL_1P);
            start2     <= (state_nxt == START) && (sel_nxt == SEL_2P);
            busy       <= (state_nxt != IDLE);
        end
    end
endmodule
